mem_access: RTL and testbench
=============================

# mem_access

MEM stage of the five-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register, and consumes that register's ALU-op, address, store-data and write-back fields. It runs a registered request/acknowledge transaction to data memory for loads and stores, and stalls the front of the pipeline until the transaction ends. It then forwards the destination number, write enable and result (sign- or zero-extended load data, or the pass-through ALU result) to write-back.

## Interface
- `TIMEOUT`, default 15: maximum cycles in BUSY waiting for `dmemAck` before the access is aborted (1..255).
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset. Low clears all state immediately.
- `memALUop` in 5: operation code. LB=5'h10, LH=5'h11, LW=5'h12, LBU=5'h13, LHU=5'h14, SB=5'h15, SH=5'h16, SW=5'h17. Any other code is a non-memory op.
- `memAddr` in 32: effective byte address.
- `memReg` in 32: store source data.
- `memWriteNum` in 5: destination register number.
- `memWriteReg` in 1: register write enable.
- `memWriteData` in 32: ALU result.
- `dmemReq` out 1: registered bus request.
- `dmemWe` out 1: 1 = store.
- `dmemAddr` out 32: word-aligned address, `{memAddr[31:2],2'b00}`.
- `dmemBe` out 4: byte enables.
- `dmemWdata` out 32: lane-replicated store data.
- `dmemRdata` in 32: read data, valid with `dmemAck`.
- `dmemAck` in 1: one-cycle completion strobe.
- `stallReq` out 1: hold EX/MEM and all earlier stages.
- `wbWriteNum` out 5: destination register number to MEM/WB.
- `wbWriteReg` out 1: register write enable to MEM/WB.
- `wbWriteData` out 32: result data to MEM/WB.
- `misalign` out 1: registered one-cycle error pulse.
- `busErr` out 1: registered one-cycle error pulse.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- **Memory op:** a memory op is a code in 5'h10..5'h17.
- **Misaligned:** an access is misaligned when it is LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0.
- **IDLE, aligned memory op:**
  - `stallReq`=1 combinationally.
  - On the next edge: latch `dmemAddr`, `dmemWe`, `dmemBe`, `dmemWdata`, the op, and `addr[1:0]`.
  - Set `dmemReq`=1, clear the timeout counter, and go to BUSY.
- **IDLE, misaligned memory op:**
  - No bus access and no stall.
  - `wbWriteReg` is forced to 0.
  - `misalign` pulses 1 on the following cycle.
- **IDLE, non-memory op:** `wb*` equals `mem*` pass-through.
- **BUSY:**
  - `stallReq`=1 and `dmemReq` held at 1.
  - The counter increments each cycle.
  - On `dmemAck`: capture `dmemRdata` into the load buffer, drop `dmemReq`, and go to DONE.
  - If the counter reaches `TIMEOUT` without an ack: drop `dmemReq`, set the abort flag, pulse `busErr`, and go to DONE.
- **DONE:**
  - `stallReq`=0.
  - Loads: `wbWriteData` is the extended load-buffer value.
  - Stores: `wbWriteData` is `memWriteData`.
  - If aborted: `wbWriteReg`=0.
  - Always go to IDLE on the next edge. EX/MEM advances on that same edge, so the instruction is not re-issued.
- **Write-back gating:** while `stallReq`=1, `wbWriteReg`=0 (the bubble presented to MEM/WB).
- **Store encoding:**
  - SB: `dmemBe`=`4'b0001<<addr[1:0]`, `dmemWdata`=`{4{memReg[7:0]}}`.
  - SH: `dmemBe`=`addr[1] ? 4'b1100 : 4'b0011`, `dmemWdata`=`{2{memReg[15:0]}}`.
  - SW: `dmemBe`=4'b1111, `dmemWdata`=`memReg`.
- **Load encoding:**
  - All loads: `dmemBe`=4'b1111, `dmemWe`=0.
  - Byte lane is selected by `addr[1:0]`; half lane by `addr[1]`.
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
- **Reset mid-transaction:** asynchronous return to IDLE with `dmemReq`=0, counter=0, buffer=0, flags=0. A late `dmemAck` arriving in IDLE is ignored.
- **Ack timing:** an ack in the same cycle the counter hits `TIMEOUT` counts as success (ack wins).

## Timing
- **Reset values:**
  - `dmemReq`=0, `dmemWe`=0, `dmemAddr`=0, `dmemBe`=0, `dmemWdata`=0.
  - `misalign`=0, `busErr`=0, `stallReq`=0.
  - `wb*` follow their inputs per the IDLE rules.
- **Latency:** with ack on the first BUSY cycle, a memory op occupies 3 cycles (IDLE, BUSY, DONE), i.e. 2 stall cycles. Each extra wait cycle adds one.
- `dmemReq` rises on the edge after IDLE detection and falls on the edge after ack.
- **Non-memory ops:** zero added latency and no stall.
- **Back-to-back memory ops:** DONE is followed by IDLE, which issues the next request one cycle later; there are no idle gaps beyond that.

## Test plan
- **LW, no wait:** LW, addr=0x100, ack in the first BUSY cycle with rdata=0xDEADBEEF → `dmemReq` high 1 cycle, `stallReq` high 2 cycles, DONE gives `wbWriteData`=0xDEADBEEF, `wbWriteReg`=1.
- **LB/LBU lane select:** LB addr=0x103, rdata=0x80123456 → 0xFFFFFF80. LBU same → 0x00000080. LHU addr=0x102 → 0x00008012.
- **Store encoding:** SB addr=0x201, memReg=0x000000AB → `dmemBe`=0010, `dmemWdata`=0xABABABAB, `dmemWe`=1. SH addr=0x202 → `dmemBe`=1100.
- **Misaligned:** LW addr=0x102 → no `dmemReq`, `stallReq`=0, `wbWriteReg`=0, `misalign` pulses once.
- **Timeout:** `TIMEOUT`=4, ack never arrives → `dmemReq` high 4 cycles, `busErr` pulse, `wbWriteReg`=0 in DONE. Repeat with ack arriving on the 4th cycle → success.
- **Reset mid-BUSY:** deassert `rst` in BUSY → `dmemReq`=0 immediately, state IDLE. An ack on the next cycle produces no write-back.

Source files
------------

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM pipeline stage: registered request/acknowledge data memory access
module mem_access #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  memALUop,
    input  logic [31:0] memAddr,
    input  logic [31:0] memReg,
    input  logic [4:0]  memWriteNum,
    input  logic        memWriteReg,
    input  logic [31:0] memWriteData,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [3:0]  dmemBe,
    output logic [31:0] dmemWdata,
    input  logic [31:0] dmemRdata,
    input  logic        dmemAck,
    output logic        stallReq,
    output logic [4:0]  wbWriteNum,
    output logic        wbWriteReg,
    output logic [31:0] wbWriteData,
    output logic        misalign,
    output logic        busErr
);

    localparam logic [4:0] OP_LH  = 5'h11;
    localparam logic [4:0] OP_LW  = 5'h12;
    localparam logic [4:0] OP_LHU = 5'h14;
    localparam logic [4:0] OP_SH  = 5'h16;
    localparam logic [4:0] OP_SW  = 5'h17;

    // Last counter value still allowed to wait; the ack is checked before it, so ack wins.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic [31:0] load_buf;
    logic        aborted;

    logic        is_mem;
    logic        misal;
    logic        start;
    logic        nxt_we;
    logic [3:0]  nxt_be;
    logic [31:0] nxt_wdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic        is_load_q;

    assign is_mem    = (memALUop[4:3] == 2'b10);
    assign start     = is_mem && !misal;
    assign is_load_q = (op_q <= 3'd4);

    // Alignment rule: halves need an even address, words need a multiple of four.
    always_comb begin
        misal = 1'b0;
        case (memALUop)
            OP_LH, OP_LHU, OP_SH: misal = memAddr[0];
            OP_LW, OP_SW:         misal = |memAddr[1:0];
            default:              misal = 1'b0;
        endcase
    end

    // Bus encoding for the op currently offered by EX/MEM; loads read the whole word.
    always_comb begin
        nxt_we    = 1'b0;
        nxt_be    = 4'b1111;
        nxt_wdata = 32'h0;
        case (memALUop[2:0])
            3'd5: begin
                nxt_we    = 1'b1;
                nxt_be    = 4'b0001 << memAddr[1:0];
                nxt_wdata = {4{memReg[7:0]}};
            end
            3'd6: begin
                nxt_we    = 1'b1;
                nxt_be    = memAddr[1] ? 4'b1100 : 4'b0011;
                nxt_wdata = {2{memReg[15:0]}};
            end
            3'd7: begin
                nxt_we    = 1'b1;
                nxt_be    = 4'b1111;
                nxt_wdata = memReg;
            end
            default: ;
        endcase
    end

    // Lane select and sign/zero extension of the captured load word.
    always_comb begin
        byte_sel = load_buf[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? load_buf[31:16] : load_buf[15:0];
        case (op_q)
            3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
            3'd3:    load_ext = {24'h0, byte_sel};
            3'd4:    load_ext = {16'h0, half_sel};
            default: load_ext = load_buf;
        endcase
    end

    // Stall and write-back selection; a stalled cycle presents a bubble to MEM/WB.
    always_comb begin
        stallReq    = ((state == IDLE) && start) || (state == BUSY);
        wbWriteNum  = memWriteNum;
        wbWriteReg  = memWriteReg;
        wbWriteData = memWriteData;
        if (state == DONE) begin
            if (is_load_q) wbWriteData = load_ext;
            if (aborted)   wbWriteReg  = 1'b0;
        end
        if ((state == IDLE) && is_mem && misal) wbWriteReg = 1'b0;
        if (stallReq) wbWriteReg = 1'b0;
    end

    // Transaction FSM with registered bus request and error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 8'h0;
            op_q      <= 3'h0;
            lane_q    <= 2'h0;
            load_buf  <= 32'h0;
            aborted   <= 1'b0;
            dmemReq   <= 1'b0;
            dmemWe    <= 1'b0;
            dmemAddr  <= 32'h0;
            dmemBe    <= 4'h0;
            dmemWdata <= 32'h0;
            misalign  <= 1'b0;
            busErr    <= 1'b0;
        end else begin
            misalign <= 1'b0;
            busErr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dmemAddr  <= {memAddr[31:2], 2'b00};
                        dmemWe    <= nxt_we;
                        dmemBe    <= nxt_be;
                        dmemWdata <= nxt_wdata;
                        op_q      <= memALUop[2:0];
                        lane_q    <= memAddr[1:0];
                        dmemReq   <= 1'b1;
                        cnt       <= 8'h0;
                        aborted   <= 1'b0;
                        state     <= BUSY;
                    end else if (is_mem) begin
                        misalign <= 1'b1;
                    end
                end
                BUSY: begin
                    if (dmemAck) begin
                        load_buf <= dmemRdata;
                        dmemReq  <= 1'b0;
                        state    <= DONE;
                    end else if (cnt == TO_LAST) begin
                        dmemReq <= 1'b0;
                        aborted <= 1'b1;
                        busErr  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 8'h1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized self-checking bench for mem_access against a behavioural model
module tb_mem_access;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  memALUop;
    logic [31:0] memAddr;
    logic [31:0] memReg;
    logic [4:0]  memWriteNum;
    logic        memWriteReg;
    logic [31:0] memWriteData;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [3:0]  dmemBe;
    logic [31:0] dmemWdata;
    logic [31:0] dmemRdata;
    logic        dmemAck;
    logic        stallReq;
    logic [4:0]  wbWriteNum;
    logic        wbWriteReg;
    logic [31:0] wbWriteData;
    logic        misalign;
    logic        busErr;

    int n_vec = 0;
    int n_err = 0;

    mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .memALUop(memALUop), .memAddr(memAddr), .memReg(memReg),
        .memWriteNum(memWriteNum), .memWriteReg(memWriteReg), .memWriteData(memWriteData),
        .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemBe(dmemBe),
        .dmemWdata(dmemWdata), .dmemRdata(dmemRdata), .dmemAck(dmemAck),
        .stallReq(stallReq), .wbWriteNum(wbWriteNum), .wbWriteReg(wbWriteReg),
        .wbWriteData(wbWriteData), .misalign(misalign), .busErr(busErr)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit m_is_mem(input logic [4:0] op);
        return (op >= 5'h10) && (op <= 5'h17);
    endfunction

    function automatic bit m_is_load(input logic [4:0] op);
        return (op >= 5'h10) && (op <= 5'h14);
    endfunction

    function automatic bit m_misal(input logic [4:0] op, input logic [31:0] a);
        int lo = int'(a % 4);
        if (op == 5'h11 || op == 5'h14 || op == 5'h16) return (lo % 2) != 0;
        if (op == 5'h12 || op == 5'h17) return lo != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [4:0] op, input logic [31:0] a);
        int lo = int'(a % 4);
        if (op == 5'h15) return 4'(1 << lo);
        if (op == 5'h16) return (lo >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [4:0] op, input logic [31:0] r);
        if (op == 5'h15) return (r % 256) * 32'h01010101;
        if (op == 5'h16) return (r % 65536) * 32'h00010001;
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d);
        int lo = int'(a % 4);
        longint b = longint'((d >> (8 * lo)) % 256);
        longint h = longint'((d >> ((lo >= 2) ? 16 : 0)) % 65536);
        case (op)
            5'h10:   return 32'((b > 127) ? b - 256 : b);
            5'h11:   return 32'((h > 32767) ? h - 65536 : h);
            5'h13:   return 32'(b);
            5'h14:   return 32'(h);
            default: return d;
        endcase
    endfunction

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] r,
                         input logic [4:0] num, input logic we, input logic [31:0] alu);
        memALUop = op; memAddr = a; memReg = r;
        memWriteNum = num; memWriteReg = we; memWriteData = alu;
    endtask

    // ack_at: BUSY cycle (1-based) that carries the ack; beyond TO means it never comes
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] r,
                          input logic [4:0] num, input logic we, input logic [31:0] alu,
                          input int ack_at, input logic [31:0] rd);
        int  i = 0;
        bit  fin = 1'b0;
        bit  abort = (ack_at > TO);
        @(posedge clk); #1;
        drive(op, a, r, num, we, alu);
        dmemAck = 1'b0;
        @(negedge clk);
        if (!m_is_mem(op)) begin
            expect_eq("pass_num", 32'(wbWriteNum), 32'(num));
            expect_eq("pass_we", 32'(wbWriteReg), 32'(we));
            expect_eq("pass_data", wbWriteData, alu);
            expect_eq("pass_stall", 32'(stallReq), 32'd0);
            expect_eq("pass_req", 32'(dmemReq), 32'd0);
            expect_eq("pass_busErr", 32'(busErr), 32'd0);
            expect_eq("pass_misalign", 32'(misalign), 32'd0);
        end else if (m_misal(op, a)) begin
            expect_eq("mis_stall", 32'(stallReq), 32'd0);
            expect_eq("mis_req", 32'(dmemReq), 32'd0);
            expect_eq("mis_we", 32'(wbWriteReg), 32'd0);
            expect_eq("mis_pulse_early", 32'(misalign), 32'd0);
            @(posedge clk); #1;
            drive(5'h00, a, r, num, 1'b0, alu);
            @(negedge clk);
            expect_eq("mis_pulse", 32'(misalign), 32'd1);
            expect_eq("mis_req_after", 32'(dmemReq), 32'd0);
        end else begin
            expect_eq("idle_stall", 32'(stallReq), 32'd1);
            expect_eq("idle_we", 32'(wbWriteReg), 32'd0);
            expect_eq("idle_req", 32'(dmemReq), 32'd0);
            while (!fin) begin
                @(posedge clk); #1;
                i++;
                dmemAck   = (i == ack_at);
                dmemRdata = (i == ack_at) ? rd : $urandom;
                @(negedge clk);
                expect_eq("busy_req", 32'(dmemReq), 32'd1);
                expect_eq("busy_stall", 32'(stallReq), 32'd1);
                expect_eq("busy_we", 32'(wbWriteReg), 32'd0);
                if (i == 1) begin
                    expect_eq("bus_addr", dmemAddr, {a[31:2], 2'b00});
                    expect_eq("bus_we", 32'(dmemWe), 32'(!m_is_load(op)));
                    expect_eq("bus_be", 32'(dmemBe), 32'(m_be(op, a)));
                    if (!m_is_load(op)) expect_eq("bus_wdata", dmemWdata, m_wdata(op, r));
                end
                if (i == ack_at || i >= TO) fin = 1'b1;
            end
            @(posedge clk); #1;
            dmemAck = 1'b0;
            dmemRdata = $urandom;
            @(negedge clk);
            expect_eq("done_req", 32'(dmemReq), 32'd0);
            expect_eq("done_stall", 32'(stallReq), 32'd0);
            expect_eq("done_busErr", 32'(busErr), 32'(abort));
            expect_eq("done_num", 32'(wbWriteNum), 32'(num));
            expect_eq("done_we", 32'(wbWriteReg), 32'(abort ? 1'b0 : we));
            if (!abort || !m_is_load(op))
                expect_eq("done_data", wbWriteData, m_is_load(op) ? m_load(op, a, rd) : alu);
        end
    endtask

    logic [4:0]  r_op;
    logic [31:0] r_addr;

    initial begin
        rst = 1'b0;
        dmemAck = 1'b0;
        dmemRdata = 32'h0;
        drive(5'h03, 32'h1234_5678, 32'h0, 5'd7, 1'b1, 32'hCAFE_0001);
        repeat (2) @(negedge clk);
        expect_eq("rst_req", 32'(dmemReq), 32'd0);
        expect_eq("rst_we", 32'(dmemWe), 32'd0);
        expect_eq("rst_addr", dmemAddr, 32'd0);
        expect_eq("rst_be", 32'(dmemBe), 32'd0);
        expect_eq("rst_wdata", dmemWdata, 32'd0);
        expect_eq("rst_misalign", 32'(misalign), 32'd0);
        expect_eq("rst_busErr", 32'(busErr), 32'd0);
        expect_eq("rst_stall", 32'(stallReq), 32'd0);
        expect_eq("rst_wbdata", wbWriteData, 32'hCAFE_0001);
        @(posedge clk); #1;
        rst = 1'b1;

        run_op(5'h12, 32'h100, 32'h0, 5'd1, 1'b1, 32'h0, 1, 32'hDEAD_BEEF);
        run_op(5'h10, 32'h103, 32'h0, 5'd2, 1'b1, 32'h0, 1, 32'h8012_3456);
        run_op(5'h13, 32'h103, 32'h0, 5'd3, 1'b1, 32'h0, 1, 32'h8012_3456);
        run_op(5'h14, 32'h102, 32'h0, 5'd4, 1'b1, 32'h0, 2, 32'h8012_3456);
        run_op(5'h15, 32'h201, 32'hAB, 5'd0, 1'b0, 32'h201, 1, 32'h0);
        run_op(5'h16, 32'h202, 32'h1234_5678, 5'd0, 1'b0, 32'h202, 3, 32'h0);
        run_op(5'h12, 32'h102, 32'h0, 5'd5, 1'b1, 32'h0, 1, 32'h0);
        run_op(5'h12, 32'h400, 32'h0, 5'd6, 1'b1, 32'h0, TO + 1, 32'h1111_2222);
        run_op(5'h12, 32'h400, 32'h0, 5'd6, 1'b1, 32'h0, TO, 32'h3333_4444);
        run_op(5'h01, 32'h0, 32'h0, 5'd9, 1'b1, 32'h5555_AAAA, 1, 32'h0);

        // Reset in the middle of a BUSY phase, then a stale ack
        @(posedge clk); #1;
        drive(5'h12, 32'h300, 32'h0, 5'd8, 1'b1, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        expect_eq("mid_req_before", 32'(dmemReq), 32'd1);
        #2;
        rst = 1'b0;
        drive(5'h02, 32'h0, 32'h0, 5'd8, 1'b0, 32'h0);
        #1;
        expect_eq("mid_req_rst", 32'(dmemReq), 32'd0);
        expect_eq("mid_stall_rst", 32'(stallReq), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        dmemAck = 1'b1;
        dmemRdata = 32'h7777_7777;
        @(negedge clk);
        expect_eq("late_ack_req", 32'(dmemReq), 32'd0);
        expect_eq("late_ack_we", 32'(wbWriteReg), 32'd0);
        expect_eq("late_ack_stall", 32'(stallReq), 32'd0);
        @(posedge clk); #1;
        dmemAck = 1'b0;
        @(negedge clk);
        expect_eq("late_ack_req2", 32'(dmemReq), 32'd0);
        expect_eq("late_ack_busErr", 32'(busErr), 32'd0);

        for (int k = 0; k < 200; k++) begin
            r_op = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) r_op = 5'h10 + 5'($urandom_range(0, 7));
            r_addr = $urandom;
            if ($urandom_range(0, 1) != 0) r_addr[1:0] = 2'b00;
            run_op(r_op, r_addr, $urandom, 5'($urandom), 1'($urandom), $urandom,
                   $urandom_range(1, TO + 2), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
